// File: rtl/alu_issuer.sv
// Command FIFO + issue sequencer that drives an external combinational ALU and returns tagged responses.
// Optional macro ALU_ISSUER_FLAGCHK_EN adds a check of returned ALU class flags against the opcode.
module alu_issuer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic [3:0]  cmd_tag,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    input  logic [15:0] alu_out,
    input  logic        alu_arith_flag,
    input  logic        alu_logic_flag,
    input  logic        alu_cmp_flag,
    input  logic        alu_shift_flag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_tag,
    output logic [3:0]  rsp_class,
    output logic        rsp_divz,
    output logic        rsp_err,
    output logic        busy
);

    // state | meaning
    // IDLE  | nothing in flight; waits for a queued command
    // ISSUE | alu_* driven, ALU settling; result captured at end of cycle
    // RESP  | response presented until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
    } cmd_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t         r_state;
    state_t         w_nxt_state;
    cmd_t           r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;
    logic           w_load;
    logic           w_capture;
    cmd_t           w_head;
    cmd_t           w_cmd_in;
    logic           w_divz;
    logic [3:0]     w_class;

    logic [3:0]     r_alu_opcode;
    logic [15:0]    r_alu_op1;
    logic [15:0]    r_alu_op2;
    logic [15:0]    r_rsp_data;
    logic [3:0]     r_rsp_tag;
    logic [3:0]     r_rsp_class;
    logic           r_rsp_divz;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;
    assign w_pop     = w_capture;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_cmd_in  = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, tag: cmd_tag};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // A push landing on the same edge is not visible here: r_count is pre-edge.
    always_comb begin
        w_nxt_state = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_nxt_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_capture   = 1'b1;
                w_nxt_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (!w_empty) begin
                        w_load      = 1'b1;
                        w_nxt_state = S_ISSUE;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign w_divz  = (r_alu_opcode == 4'b0011) && (r_alu_op2 == 16'h0000);
    assign w_class = {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
        end else if (w_load) begin
            r_alu_opcode <= w_head.opcode;
            r_alu_op1    <= w_head.a;
            r_alu_op2    <= w_head.b;
        end
    end

    // The head entry is still the in-flight command during ISSUE; it is popped on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
            r_rsp_class <= '0;
            r_rsp_divz  <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data  <= w_divz ? 16'hFFFF : alu_out;
            r_rsp_tag   <= w_head.tag;
            r_rsp_class <= w_class;
            r_rsp_divz  <= w_divz;
        end
    end

`ifdef ALU_ISSUER_FLAGCHK_EN
    logic       r_rsp_err;
    logic [3:0] w_exp_class;

    always_comb begin
        w_exp_class = 4'b0000;
        if (r_alu_opcode <= 4'd3) begin
            w_exp_class = 4'b1000;
        end else if (r_alu_opcode <= 4'd9) begin
            w_exp_class = 4'b0100;
        end else if (r_alu_opcode <= 4'd12) begin
            w_exp_class = 4'b0010;
        end else if (r_alu_opcode <= 4'd14) begin
            w_exp_class = 4'b0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (w_capture) begin
            r_rsp_err <= (w_class != w_exp_class);
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_class  = r_rsp_class;
    assign rsp_divz   = r_rsp_divz;
    assign busy       = !w_empty || (r_state != S_IDLE);

endmodule
